// File: rtl/mux4_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: channel count, select width
// and the scan FSM state encoding.
package mux4_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/rr_next_ch.sv
// Round-robin channel pick: first set bit of i_req strictly above i_cur, wrapping.
// Passing i_cur = NUM_CH-1 yields the lowest set bit, which is how the start pick is made.
module rr_next_ch
  import mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_cur,
  output logic [CH_W-1:0]   o_nxt,
  output logic              o_wrap
);

  logic            w_found;
  logic [CH_W-1:0] w_idx;

  always_comb begin
    o_nxt   = i_cur;
    w_found = 1'b0;
    w_idx   = i_cur;
    for (int i = 1; i < NUM_CH; i++) begin
      w_idx = i_cur + CH_W'(i);
      if (!w_found && i_req[w_idx]) begin
        o_nxt   = w_idx;
        w_found = 1'b1;
      end
    end
    // No other channel enabled keeps the current one, which counts as a wrap.
    o_wrap = (o_nxt <= i_cur);
  end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: holds each enabled channel's select for DWELL cycles,
// captures the mux output into a per-channel sample bit and flags captures and sweeps.
module mux4_scan_ctrl
  import mux4_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  input  logic              f,
  output logic              s1,
  output logic              s0,
  output logic [NUM_CH-1:0] sample,
  output logic              sample_vld,
  output logic [CH_W-1:0]   sample_ch,
  output logic              frame_done,
  output state_e            o_dbg_state
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL - 1);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]   r_sel, w_sel_nxt;
  logic [NUM_CH-1:0] r_sample, w_sample_nxt;
  logic [CH_W-1:0]   r_sample_ch, w_sample_ch_nxt;
  logic              r_vld, w_vld_nxt;
  logic              r_frame, w_frame_nxt;

  logic [CH_W-1:0]   w_cur;
  logic [CH_W-1:0]   w_pick;
  logic              w_wrap;

  assign w_cur = (r_state == ST_IDLE) ? CH_W'(NUM_CH - 1) : r_sel;

  rr_next_ch u_rr (
    .i_req  (req),
    .i_cur  (w_cur),
    .o_nxt  (w_pick),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sel_nxt       = r_sel;
    w_sample_nxt    = r_sample;
    w_sample_ch_nxt = r_sample_ch;
    w_vld_nxt       = 1'b0;
    w_frame_nxt     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (en && (|req)) begin
          w_state_nxt = ST_SCAN;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          // req is only looked at here, so mid-dwell changes never cut a dwell short.
          w_sample_nxt[r_sel] = f;
          w_sample_ch_nxt     = r_sel;
          w_vld_nxt           = 1'b1;
          w_cnt_nxt           = '0;
          if (req == '0) begin
            w_state_nxt = ST_IDLE;
            w_frame_nxt = 1'b1;
          end else begin
            w_sel_nxt   = w_pick;
            w_frame_nxt = w_wrap;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_sample    <= '0;
      r_sample_ch <= '0;
      r_vld       <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel       <= w_sel_nxt;
      r_sample    <= w_sample_nxt;
      r_sample_ch <= w_sample_ch_nxt;
      r_vld       <= w_vld_nxt;
      r_frame     <= w_frame_nxt;
    end
  end

  // sample_vld is a one-cycle pulse with no back-pressure: sample[sample_ch] and
  // frame_done are valid in exactly the cycle it is high, and nothing stalls the scan.
  assign s1          = r_sel[1];
  assign s0          = r_sel[0];
  assign sample      = r_sample;
  assign sample_vld  = r_vld;
  assign sample_ch   = r_sample_ch;
  assign frame_done  = r_frame;
  assign o_dbg_state = r_state;

endmodule
